// File: rtl/axi_mem_responder.sv
// AXI4 slave backed by an internal word-addressed memory. Independent write and
// read engines, one outstanding burst each; FIXED/INCR/WRAP, narrow sizes, strobes.
module axi_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4
) (
  input  logic                    aclk,
  input  logic                    reset,
  // write address
  input  logic [ID_WIDTH-1:0]     s_awid,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic [7:0]              s_awlen,
  input  logic [2:0]              s_awsize,
  input  logic [1:0]              s_awburst,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  // write data
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wlast,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  // write response
  output logic [ID_WIDTH-1:0]     s_bid,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  // read address
  input  logic [ID_WIDTH-1:0]     s_arid,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic [7:0]              s_arlen,
  input  logic [2:0]              s_arsize,
  input  logic [1:0]              s_arburst,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  // read data
  output logic [ID_WIDTH-1:0]     s_rid,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rlast,
  output logic                    s_rvalid,
  input  logic                    s_rready
);

  localparam int unsigned StrbWidth = DATA_WIDTH / 8;
  localparam int unsigned ByteBits  = $clog2(StrbWidth);
  localparam int unsigned Words     = 1 << (ADDR_WIDTH - ByteBits);
  localparam logic [2:0]  MaxSize   = 3'(ByteBits);
  localparam logic [1:0]  RespOkay  = 2'b00;
  localparam logic [1:0]  RespSlv   = 2'b10;
  localparam logic [1:0]  BurstFix  = 2'b00;
  localparam logic [1:0]  BurstWrap = 2'b10;

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic {RIdle, RData} r_state_e;

  logic [DATA_WIDTH-1:0] mem [Words];

  // Address of the beat following 'a' for the given burst shape.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [7:0] len,
                                                      input logic [2:0] size,
                                                      input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] step, mask, inc;
    step = ADDR_WIDTH'(1) << size;
    mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    inc  = a + step;
    if (burst == BurstFix) return a;
    if (burst == BurstWrap) return (a & ~mask) | (inc & mask);
    return inc;
  endfunction

  function automatic logic burst_err(input logic [7:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
    logic bad_wrap;
    bad_wrap = (burst == BurstWrap) &&
               !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    return (burst == 2'b11) || bad_wrap || (size > MaxSize);
  endfunction

  // ---------------------------------------------------------------- write engine
  w_state_e              w_state_q, w_state_d;
  logic                  awready_q, wready_q, bvalid_q;
  logic [ID_WIDTH-1:0]   bid_q;
  logic [1:0]            bresp_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [7:0]            wlen_q, wcnt_q;
  logic [2:0]            wsize_q;
  logic [1:0]            wburst_q;
  logic                  werr_q, wlast_err_q;

  logic aw_fire, w_fire, b_fire, w_is_last, wlast_bad;
  assign aw_fire   = s_awvalid && awready_q;
  assign w_fire    = s_wvalid && wready_q;
  assign b_fire    = bvalid_q && s_bready;
  assign w_is_last = (wcnt_q == wlen_q);
  assign wlast_bad = (s_wlast != w_is_last);

  // Write FSM next state.
  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      WIdle:   if (aw_fire) w_state_d = WData;
      WData:   if (w_fire && w_is_last) w_state_d = WResp;
      WResp:   if (b_fire) w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
  end

  // Write state, registered handshake outputs and burst bookkeeping.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      w_state_q   <= WIdle;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= RespOkay;
      waddr_q     <= '0;
      wlen_q      <= '0;
      wcnt_q      <= '0;
      wsize_q     <= '0;
      wburst_q    <= '0;
      werr_q      <= 1'b0;
      wlast_err_q <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= (w_state_d == WIdle);
      wready_q  <= (w_state_d == WData);
      bvalid_q  <= (w_state_d == WResp);
      if (aw_fire) begin
        bid_q       <= s_awid;
        waddr_q     <= s_awaddr;
        wlen_q      <= s_awlen;
        wsize_q     <= s_awsize;
        wburst_q    <= s_awburst;
        wcnt_q      <= '0;
        werr_q      <= burst_err(s_awlen, s_awsize, s_awburst);
        wlast_err_q <= 1'b0;
      end else if (w_fire) begin
        waddr_q     <= next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
        wcnt_q      <= wcnt_q + 8'd1;
        wlast_err_q <= wlast_err_q | wlast_bad;
        if (w_is_last) begin
          bresp_q <= (werr_q || wlast_err_q || wlast_bad) ? RespSlv : RespOkay;
        end
      end
    end
  end

  // Byte-lane memory write; erroneous bursts never touch the array.
  always_ff @(posedge aclk) begin
    if (w_fire && !werr_q) begin
      for (int unsigned b = 0; b < StrbWidth; b++) begin
        if (s_wstrb[b]) mem[waddr_q[ADDR_WIDTH-1:ByteBits]][8*b +: 8] <= s_wdata[8*b +: 8];
      end
    end
  end

  assign s_awready = awready_q;
  assign s_wready  = wready_q;
  assign s_bvalid  = bvalid_q;
  assign s_bid     = bid_q;
  assign s_bresp   = bresp_q;

  // ----------------------------------------------------------------- read engine
  r_state_e              r_state_q, r_state_d;
  logic                  arready_q, rvalid_q, rlast_q, rerr_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic [ADDR_WIDTH-1:0] raddr_q;  // address of the next beat to load
  logic [7:0]            rlen_q, rbeat_q;
  logic [2:0]            rsize_q;
  logic [1:0]            rburst_q;

  logic ar_fire, r_fire, ar_err;
  assign ar_fire = s_arvalid && arready_q;
  assign r_fire  = rvalid_q && s_rready;
  assign ar_err  = burst_err(s_arlen, s_arsize, s_arburst);

  // Read FSM next state.
  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      RIdle:   if (ar_fire) r_state_d = RData;
      RData:   if (r_fire && rlast_q) r_state_d = RIdle;
      default: r_state_d = RIdle;
    endcase
  end

  // Read state and output register; mem is sampled before any same-edge write lands.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      r_state_q <= RIdle;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rerr_q    <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= RespOkay;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rbeat_q   <= '0;
      rsize_q   <= '0;
      rburst_q  <= '0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= (r_state_d == RIdle);
      rvalid_q  <= (r_state_d == RData);
      if (ar_fire) begin
        rid_q    <= s_arid;
        rlen_q   <= s_arlen;
        rsize_q  <= s_arsize;
        rburst_q <= s_arburst;
        rerr_q   <= ar_err;
        rresp_q  <= ar_err ? RespSlv : RespOkay;
        rdata_q  <= ar_err ? '0 : mem[s_araddr[ADDR_WIDTH-1:ByteBits]];
        rlast_q  <= (s_arlen == 8'd0);
        rbeat_q  <= '0;
        raddr_q  <= next_addr(s_araddr, s_arlen, s_arsize, s_arburst);
      end else if (r_fire && !rlast_q) begin
        rdata_q <= rerr_q ? '0 : mem[raddr_q[ADDR_WIDTH-1:ByteBits]];
        raddr_q <= next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
        rbeat_q <= rbeat_q + 8'd1;
        rlast_q <= ((rbeat_q + 8'd1) == rlen_q);
      end else if (r_fire) begin
        rlast_q <= 1'b0;
      end
    end
  end

  assign s_arready = arready_q;
  assign s_rvalid  = rvalid_q;
  assign s_rid     = rid_q;
  assign s_rdata   = rdata_q;
  assign s_rresp   = rresp_q;
  assign s_rlast   = rlast_q;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Scoreboard bench for axi_mem_responder: tasks push expected B/R responses,
// a negedge monitor pops and compares on every handshake.
module tb_axi_mem_responder;

  logic        aclk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  s_awid, s_arid, s_bid, s_rid;
  logic [11:0] s_awaddr, s_araddr;
  logic [7:0]  s_awlen, s_arlen;
  logic [2:0]  s_awsize, s_arsize;
  logic [1:0]  s_awburst, s_arburst, s_bresp, s_rresp;
  logic        s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
  logic [31:0] s_wdata, s_rdata;
  logic [3:0]  s_wstrb;

  always #5 aclk = ~aclk;

  axi_mem_responder #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .ID_WIDTH(4)) dut (
    .aclk(aclk), .reset(reset),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
    .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  localparam logic [1:0] OK = 2'b00, SLV = 2'b10;
  localparam logic [1:0] FIX = 2'b00, INC = 2'b01, WRP = 2'b10;

  typedef struct packed {logic [3:0] id; logic [1:0] resp;} b_exp_t;
  typedef struct packed {
    logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; logic consec;
  } r_exp_t;

  b_exp_t      b_q[$];
  r_exp_t      r_q[$];
  logic [31:0] vec[$];
  int          n_vec = 0, n_err = 0;
  int          cyc = 0, last_cyc = -10;
  bit          rr_toggle = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // rready: held high, or toggled every cycle to exercise backpressure.
  initial begin
    s_rready = 1'b1;
    forever begin
      @(posedge aclk); #1;
      s_rready = rr_toggle ? ~s_rready : 1'b1;
    end
  end

  // Monitor: compare each B/R handshake against the scoreboard; check R hold on stall.
  logic        held;
  logic [38:0] held_val;
  b_exp_t      be;
  r_exp_t      re;
  always @(negedge aclk) begin
    cyc++;
    if (reset) begin
      held = 1'b0;
    end else begin
      if (s_arvalid && s_arready) last_cyc = cyc;
      if (s_bvalid && s_bready) begin
        if (b_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL b_unexpected: got bid %h bresp %h with nothing expected", s_bid, s_bresp);
        end else begin
          be = b_q.pop_front();
          chk("b_resp", {s_bid, s_bresp}, {be.id, be.resp});
        end
      end
      if (s_rvalid) begin
        if (held) chk("r_stable", {s_rid, s_rdata, s_rresp, s_rlast}, held_val);
        if (s_rready) begin
          held = 1'b0;
          if (r_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL r_unexpected: got rdata %h with nothing expected", s_rdata);
          end else begin
            re = r_q.pop_front();
            chk("r_beat", {s_rid, s_rdata, s_rresp, s_rlast}, {re.id, re.data, re.resp, re.last});
            if (re.consec) chk("r_full_rate", 64'(cyc), 64'(last_cyc + 1));
          end
          last_cyc = cyc;
        end else begin
          held = 1'b1;
          held_val = {s_rid, s_rdata, s_rresp, s_rlast};
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  task automatic do_write(input logic [3:0] id, input logic [11:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input logic [3:0] strb, input bit wlast_ok, input logic [1:0] resp);
    int t;
    b_q.push_back('{id: id, resp: resp});
    s_awid = id; s_awaddr = addr; s_awlen = len; s_awsize = size; s_awburst = burst;
    s_awvalid = 1'b1;
    t = 0;
    while (!s_awready && t < 50) begin @(posedge aclk); #1; t++; end
    chk("aw_accept", 64'(t < 50), 64'd1);
    @(posedge aclk); #1;
    s_awvalid = 1'b0;
    chk("wready_lat", 64'(s_wready), 64'd1);
    for (int i = 0; i <= int'(len); i++) begin
      s_wvalid = 1'b1; s_wdata = vec[i]; s_wstrb = strb;
      s_wlast = wlast_ok && (i == int'(len));
      t = 0;
      while (!s_wready && t < 50) begin @(posedge aclk); #1; t++; end
      @(posedge aclk); #1;
    end
    s_wvalid = 1'b0; s_wlast = 1'b0;
    chk("bvalid_lat", 64'(s_bvalid), 64'd1);
    t = 0;
    while (b_q.size() != 0 && t < 50) begin @(posedge aclk); #1; t++; end
    chk("b_drained", 64'(b_q.size()), 64'd0);
  endtask

  task automatic push_read(input logic [3:0] id, input logic [7:0] len, input logic [1:0] resp,
                           input bit consec);
    for (int i = 0; i <= int'(len); i++)
      r_q.push_back('{id: id, data: (resp == SLV) ? 32'h0 : vec[i], resp: resp,
                      last: (i == int'(len)), consec: consec});
  endtask

  task automatic issue_ar(input logic [3:0] id, input logic [11:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    int t;
    s_arid = id; s_araddr = addr; s_arlen = len; s_arsize = size; s_arburst = burst;
    s_arvalid = 1'b1;
    t = 0;
    while (!s_arready && t < 50) begin @(posedge aclk); #1; t++; end
    chk("ar_accept", 64'(t < 50), 64'd1);
    @(posedge aclk); #1;
    s_arvalid = 1'b0;
    chk("rvalid_lat", 64'(s_rvalid), 64'd1);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [11:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input logic [1:0] resp, input bit consec);
    int t;
    push_read(id, len, resp, consec);
    issue_ar(id, addr, len, size, burst);
    t = 0;
    while (r_q.size() != 0 && t < 200) begin @(posedge aclk); #1; t++; end
    chk("r_drained", 64'(r_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    int t;
    s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0; s_awvalid = 0;
    s_wdata = '0; s_wstrb = '0; s_wlast = 0; s_wvalid = 0; s_bready = 1'b1;
    s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0; s_arvalid = 0;
    reset = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_ready", {s_awready, s_arready, s_wready}, 3'b000);
    chk("rst_valid", {s_bvalid, s_rvalid, s_rlast}, 3'b000);
    chk("rst_data", {s_bid, s_bresp, s_rid, s_rresp, s_rdata}, 44'h0);
    @(negedge aclk); reset = 1'b0;
    @(posedge aclk); #1;
    chk("ready_after_rst", {s_awready, s_arready}, 2'b11);

    // Single write then read.
    vec = '{32'hDEADBEEF};
    do_write(4'h1, 12'h010, 8'd0, 3'd2, INC, 4'hF, 1'b1, OK);
    do_read(4'h2, 12'h010, 8'd0, 3'd2, INC, OK, 1'b0);

    // INCR burst, full-rate readback.
    vec = '{32'd1, 32'd2, 32'd3, 32'd4};
    do_write(4'h3, 12'h100, 8'd3, 3'd2, INC, 4'hF, 1'b1, OK);
    do_read(4'h4, 12'h100, 8'd3, 3'd2, INC, OK, 1'b1);

    // WRAP burst from 0x208: lands at 208,20C,200,204.
    vec = '{32'hA, 32'hB, 32'hC, 32'hD};
    do_write(4'h5, 12'h208, 8'd3, 3'd2, WRP, 4'hF, 1'b1, OK);
    vec = '{32'hC, 32'hD, 32'hA, 32'hB};
    do_read(4'h6, 12'h200, 8'd3, 3'd2, INC, OK, 1'b0);
    vec = '{32'hC, 32'hC};
    do_read(4'h7, 12'h200, 8'd1, 3'd2, FIX, OK, 1'b0);

    // Strobes, then reads under toggling rready.
    vec = '{32'h11223344};
    do_write(4'h8, 12'h040, 8'd0, 3'd2, INC, 4'hF, 1'b1, OK);
    vec = '{32'hAABBCCDD};
    do_write(4'h8, 12'h040, 8'd0, 3'd2, INC, 4'h3, 1'b1, OK);
    rr_toggle = 1'b1;
    vec = '{32'h1122CCDD};
    do_read(4'h9, 12'h040, 8'd0, 3'd2, INC, OK, 1'b0);
    vec = '{32'd1, 32'd2, 32'd3, 32'd4};
    do_read(4'hA, 12'h100, 8'd3, 3'd2, INC, OK, 1'b0);
    rr_toggle = 1'b0;

    // Errors.
    vec = '{32'h12345678};
    do_write(4'hB, 12'h080, 8'd0, 3'd2, INC, 4'hF, 1'b1, OK);
    vec = '{32'h00000055};
    do_write(4'hC, 12'h080, 8'd0, 3'd2, 2'b11, 4'hF, 1'b1, SLV);
    vec = '{32'h12345678};
    do_read(4'hD, 12'h080, 8'd0, 3'd2, INC, OK, 1'b0);
    vec = '{32'h0, 32'h0};
    do_read(4'hE, 12'h0C0, 8'd1, 3'd3, INC, SLV, 1'b0);
    vec = '{32'h66, 32'h77};
    do_write(4'hF, 12'h0C0, 8'd1, 3'd2, INC, 4'hF, 1'b0, SLV);

    // Reset during beat 2 of an 8-beat read.
    vec = '{32'h300, 32'h301, 32'h302, 32'h303, 32'h304, 32'h305, 32'h306, 32'h307};
    do_write(4'h1, 12'h300, 8'd7, 3'd2, INC, 4'hF, 1'b1, OK);
    push_read(4'h3, 8'd7, OK, 1'b1);
    issue_ar(4'h3, 12'h300, 8'd7, 3'd2, INC);
    t = 0;
    while (r_q.size() > 6 && t < 50) begin @(negedge aclk); #1; t++; end
    chk("beats_before_rst", 64'(r_q.size()), 64'd6);
    reset = 1'b1;
    #1;
    chk("midrst_valid", {s_rvalid, s_rlast, s_bvalid}, 3'b000);
    chk("midrst_ready", {s_arready, s_awready, s_wready}, 3'b000);
    chk("midrst_rdata", 64'(s_rdata), 64'd0);
    r_q.delete();
    repeat (2) @(negedge aclk);
    reset = 1'b0;
    vec = '{32'h300};
    do_read(4'h6, 12'h300, 8'd0, 3'd2, INC, OK, 1'b0);

    repeat (3) @(posedge aclk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_mem_responder.md
# axi_mem_responder

Synthesizable AXI4 slave with an internal word-addressed memory. It answers burst traffic from the master-side agents in the chip block design, so that stimulus can end on real RTL instead of a simulation-only memory model. It has one write engine and one read engine that run independently, with one outstanding transaction per direction. It handles FIXED, INCR and WRAP bursts, narrow transfers and byte strobes.

## Interface
- ADDR_WIDTH, 12, byte-address width; memory holds 2^ADDR_WIDTH bytes.
- DATA_WIDTH, 32, data bus width; legal values are 32 and 64.
- ID_WIDTH, 4, width of the AWID/ARID transaction IDs.
- aclk  in  1  sole clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- s_awid/awaddr/awlen/awsize/awburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  write address fields.
- s_awvalid in 1, s_awready out 1  write address handshake.
- s_wdata/wstrb/wlast  in  DATA_WIDTH/DATA_WIDTH/8/1  write data fields.
- s_wvalid in 1, s_wready out 1  write data handshake.
- s_bid/bresp  out  ID_WIDTH/2  write response fields.
- s_bvalid out 1, s_bready in 1  write response handshake.
- s_arid/araddr/arlen/arsize/arburst  in  read address fields, same widths as AW.
- s_arvalid in 1, s_arready out 1  read address handshake.
- s_rid/rdata/rresp/rlast  out  ID_WIDTH/DATA_WIDTH/2/1  read data fields.
- s_rvalid out 1, s_rready in 1  read data handshake.

## Operation
- **Write FSM** (W_IDLE → W_DATA → W_RESP → W_IDLE)
  - W_IDLE: awready=1. An AW handshake latches id, addr, len, size and burst, clears the beat counter and moves to W_DATA.
  - W_DATA: wready=1. On each W handshake, bytes whose wstrb bit is set are written to word addr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)]. The address then advances and the counter increments.
  - After beat awlen+1, the FSM moves to W_RESP. Beat count alone ends the burst; wlast does not.
  - W_RESP: bvalid=1 and bid is the latched id. On the B handshake the FSM returns to W_IDLE.
- **Read FSM** (R_IDLE → R_DATA → R_IDLE)
  - R_IDLE: arready=1. An AR handshake loads the rdata register from the first address, sets rvalid and rid, and sets rlast=(arlen==0).
  - R_DATA: on each R handshake with rlast=0, the next beat is loaded into rdata in the same edge. On an R handshake with rlast=1, rvalid drops and the FSM returns to R_IDLE.
  - Throughout the burst, rdata, rid, rresp and rlast hold stable while rvalid=1 and rready=0.
- **Address advance**
  - FIXED: address unchanged.
  - INCR: address += 2^size, wrapping at 2^ADDR_WIDTH.
  - WRAP: bytes = (len+1)·2^size; address = (addr & ~(bytes-1)) | ((addr + 2^size) & (bytes-1)).
- **Errors** (SLVERR=2'b10)
  - Conditions: burst==2'b11; WRAP with len not in {1,3,7,15}; size > log2(DATA_WIDTH/8).
  - Write: bursts with an error condition never modify memory. bresp=SLVERR if an error condition applies, or if wlast is asserted on any beat other than the last, or is absent on the last beat.
  - Read: every beat returns rresp=SLVERR with rdata=0. The burst still returns arlen+1 beats.
- Memory contents are not reset.
- Read and write to the same word in the same cycle: the read returns the old data.

## Timing
- Reset values: awready=0, arready=0, wready=0, bvalid=0, rvalid=0, rlast=0; bid, bresp, rid, rresp and rdata are 0.
- awready and arready rise on the first edge after reset deasserts.
- Write latency: wready is high the cycle after the AW handshake. bvalid is high the cycle after the last W handshake.
- Read latency: rvalid is high the cycle after the AR handshake. While rready is held high, the engine delivers one beat per cycle.
- Ready signals are registered and depend only on FSM state. A valid is never deasserted before its handshake.
- AW and AR accepted in the same cycle: both proceed concurrently.
- Reset asserted mid-burst: both FSMs return to IDLE and outputs take their reset values asynchronously. The partial burst is abandoned; beats already written stay in memory.

## Test plan
- **Single write then read:** AW addr 0x010, len 0, size 2, INCR, wdata 0xDEADBEEF, wstrb 0xF; then AR to 0x010 → bresp OKAY, rdata 0xDEADBEEF, rlast=1, rid equals arid.
- **INCR burst at full rate:** write 4 beats from 0x100 with data 1..4; read back with rready held high → beats arrive on 4 consecutive cycles as 1,2,3,4; rlast on beat 4 only.
- **WRAP burst:** WRAP len 3, size 2, start 0x208, data A,B,C,D → words 0x208,0x20C,0x200,0x204 hold A,B,C,D. A FIXED 2-beat read of 0x200 returns C,C.
- **Strobes and backpressure:** write 0x11223344 to 0x040, then 0xAABBCCDD with wstrb 0x3 → read returns 0x1122CCDD. Toggle rready each cycle → rdata stable while stalled.
- **Errors:** burst 2'b11 write of 0x55 to 0x080 → bresp SLVERR and word unchanged. An AR with size 3 on a 32-bit bus and len 1 → 2 beats, both rresp SLVERR, rdata 0. A 2-beat write with no wlast → bresp SLVERR.
- **Reset mid-burst:** assert reset during beat 2 of an 8-beat read → rvalid=0 immediately. After release, a new AR is accepted and its response rid matches the new arid.
